// File: rtl/mem_lsu_stage_if.sv
// DCache request/response bundle between the LSU stage (master) and the DCache (slave).
// A request transfers on a cycle where req_valid & req_ready are both high. Once raised,
// the master keeps req_valid and all request fields steady until that cycle, unless a flush
// withdraws the request. Responses have no back-pressure: resp_valid carries one load word.
interface mem_lsu_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  dcache_req_valid;
  logic                  dcache_req_ready;
  logic                  dcache_req_we;
  logic [ADDR_WIDTH-1:0] dcache_req_addr;
  logic [3:0]            dcache_req_wstrb;
  logic [31:0]           dcache_req_wdata;
  logic                  dcache_resp_valid;
  logic [31:0]           dcache_resp_rdata;

  modport master (
    output dcache_req_valid, dcache_req_we, dcache_req_addr, dcache_req_wstrb, dcache_req_wdata,
    input  dcache_req_ready, dcache_resp_valid, dcache_resp_rdata
  );

  modport slave (
    input  dcache_req_valid, dcache_req_we, dcache_req_addr, dcache_req_wstrb, dcache_req_wdata,
    output dcache_req_ready, dcache_resp_valid, dcache_resp_rdata
  );
endinterface

// File: rtl/mem_lsu_stage.sv
// First memory stage: issues one DCache access per EX result, aligns load data, registers WB.
// Optional macro MEM_LSU_LOAD_FORWARD_EN lets a completed load forward its data from DONE.
module mem_lsu_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      advance,
  output logic                      advance_ready,
  input  logic                      in_valid,
  input  logic                      in_excp,
  input  logic                      in_load,
  input  logic                      in_store,
  input  logic [1:0]                in_size,
  input  logic                      in_signed,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [31:0]               in_store_data,
  input  logic [31:0]               in_wdata,
  input  logic                      in_wreg,
  input  logic [REG_ADDR_WIDTH-1:0] in_waddr,
  mem_lsu_stage_if.master           dc,
  output logic                      fwd_wreg,
  output logic                      fwd_data_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_waddr,
  output logic [31:0]               fwd_wdata,
  output logic                      wb_valid,
  output logic                      wb_wreg,
  output logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic [31:0]               wb_wdata,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        mem_op;
  logic        req_valid;
  logic        capture;
  logic [1:0]  lane;
  logic [3:0]  strb;
  logic [31:0] store_data;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] hold;

  assign mem_op    = in_valid & (in_load | in_store) & ~in_excp;
  assign lane      = in_addr[1:0];
  assign state_dbg = state;

  always_comb begin
    strb       = 4'b1111;
    store_data = in_store_data;
    case (in_size)
      2'b00: begin
        strb       = 4'b0001 << lane;
        store_data = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        strb       = 4'b0011 << {lane[1], 1'b0};
        store_data = {2{in_store_data[15:0]}};
      end
      default: begin
        strb       = 4'b1111;
        store_data = in_store_data;
      end
    endcase
  end

  assign dc.dcache_req_valid = req_valid;
  assign dc.dcache_req_we    = in_store;
  assign dc.dcache_req_addr  = in_addr;
  assign dc.dcache_req_wstrb = strb;
  assign dc.dcache_req_wdata = store_data;

  // The DCache returns the whole aligned word; the addressed lane is moved down to bit 0.
  assign shifted = dc.dcache_resp_rdata >> {lane, 3'b000};

  always_comb begin
    load_data = shifted;
    case (in_size)
      2'b00:   load_data = in_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'b0, shifted[7:0]};
      2'b01:   load_data = in_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    req_valid     = 1'b0;
    advance_ready = 1'b0;
    capture       = 1'b0;
    case (state)
      S_IDLE: begin
        req_valid     = mem_op & ~flush;
        advance_ready = ~mem_op;
        if (req_valid && dc.dcache_req_ready) begin
          state_nxt = in_store ? S_DONE : S_WAIT;
        end else if (req_valid) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        req_valid = ~flush;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (dc.dcache_req_ready) begin
          state_nxt = in_store ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        // A response that meets a flush is simply dropped; nothing is left to drain.
        if (dc.dcache_resp_valid) begin
          capture   = ~flush;
          state_nxt = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        advance_ready = 1'b1;
        if (flush || advance) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (dc.dcache_resp_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= 32'b0;
    end else if (capture) begin
      hold <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_wreg  <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= 32'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_wreg  <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= 32'b0;
    end else if (advance) begin
      wb_valid <= in_valid;
      wb_wreg  <= in_wreg & ~in_excp;
      wb_waddr <= in_waddr;
      wb_wdata <= in_load ? hold : in_wdata;
    end
  end

  assign fwd_wreg  = in_valid & in_wreg;
  assign fwd_waddr = in_waddr;

`ifdef MEM_LSU_LOAD_FORWARD_EN
  logic load_fwd;
  assign load_fwd       = (state == S_DONE) & in_load;
  assign fwd_data_valid = fwd_wreg & (~in_load | load_fwd);
  assign fwd_wdata      = load_fwd ? hold : in_wdata;
`else
  assign fwd_data_valid = fwd_wreg & ~in_load;
  assign fwd_wdata      = in_wdata;
`endif

endmodule
